// File: rtl/button_conditioner_if.sv
// Bundle between the raw key pins and the timer core's control strobes.
// Strobes are single-cycle pulses with no back-pressure; the consumer must sample every cycle.
interface button_conditioner_if;
  logic [5:0] i_keys;
  logic       o_start_stop;
  logic       o_select_seconds;
  logic       o_select_minutes;
  logic       o_select_hours;
  logic       o_increment;
  logic       o_save;
  logic [5:0] o_keys_level;
  logic [1:0] o_dbg_state;

  modport slave (
    input  i_keys,
    output o_start_stop, o_select_seconds, o_select_minutes, o_select_hours,
    output o_increment, o_save, o_keys_level, o_dbg_state
  );

  modport master (
    output i_keys,
    input  o_start_stop, o_select_seconds, o_select_minutes, o_select_hours,
    input  o_increment, o_save, o_keys_level, o_dbg_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect six keys; the increment key also
// gets a hold-to-repeat FSM whose state is visible on o_dbg_state.
module button_conditioner #(
  parameter int unsigned CLOCK_FREQ      = 32'd50_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  button_conditioner_if.slave  io_bus
);

  localparam int unsigned DB_RAW    = CLOCK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned RD_RAW    = CLOCK_FREQ / 1000 * REPEAT_DELAY_MS;
  localparam int unsigned RR_RAW    = CLOCK_FREQ / 1000 * REPEAT_RATE_MS;
  localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int unsigned RD_CYCLES = (RD_RAW < 1) ? 1 : RD_RAW;
  localparam int unsigned RR_CYCLES = (RR_RAW < 1) ? 1 : RR_RAW;
  localparam int unsigned T_MAX     = (RD_CYCLES > RR_CYCLES) ? RD_CYCLES : RR_CYCLES;
  localparam int          CW        = $clog2(DB_CYCLES + 1);
  localparam int          TW        = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(RD_CYCLES - 1);
  localparam logic [TW-1:0] RR_LAST = TW'(RR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DELAY = 2'd1, S_REPEAT = 2'd2} state_t;

  logic [5:0]    r_sync1;
  logic [5:0]    r_sync2;
  logic [5:0]    r_db;
  logic [5:0]    r_db_q;
  logic [CW-1:0] r_cnt [6];
  logic [5:0]    r_pulse;
  state_t        r_state;
  logic [TW-1:0] r_timer;

  state_t        w_state_nxt;
  logic [TW-1:0] w_timer_nxt;
  logic          w_inc_pulse;
  logic [5:0]    w_rise;

  assign w_rise = r_db & ~r_db_q;

  // Reset clears the synchroniser to "released", so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= io_bus.i_keys ^ {6{ACTIVE_LOW}};
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 6; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // A release always beats a timer expiry in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        if (REPEAT_EN && w_rise[4]) begin
          w_state_nxt = S_DELAY;
          w_timer_nxt = RD_LAST;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (!r_db[4]) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt = S_REPEAT;
          w_timer_nxt = RR_LAST;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_inc_pulse = 1'b0;
    case (r_state)
      S_IDLE:            w_inc_pulse = w_rise[4];
      S_DELAY, S_REPEAT: w_inc_pulse = r_db[4] && (r_timer == '0);
      default:           w_inc_pulse = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse <= '0;
    end else begin
      r_pulse    <= w_rise;
      r_pulse[4] <= REPEAT_EN ? w_inc_pulse : w_rise[4];
    end
  end

  assign io_bus.o_start_stop     = r_pulse[0];
  assign io_bus.o_select_seconds = r_pulse[1];
  assign io_bus.o_select_minutes = r_pulse[2];
  assign io_bus.o_select_hours   = r_pulse[3];
  assign io_bus.o_increment      = r_pulse[4];
  assign io_bus.o_save           = r_pulse[5];
  assign io_bus.o_keys_level     = r_db;
  assign io_bus.o_dbg_state      = r_state;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB=4, RD=10, RR=3 cycles.
module tb_button_conditioner;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   rep_q[$];
  logic [5:0] pulses;
  logic [5:0] exp_p;

  button_conditioner_if bus ();

  button_conditioner #(
    .CLOCK_FREQ(32'd1000), .DEBOUNCE_MS(4), .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS(3), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .io_bus(bus.slave)
  );

  assign pulses = {bus.o_save, bus.o_increment, bus.o_select_hours,
                   bus.o_select_minutes, bus.o_select_seconds, bus.o_start_stop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step n edges, expecting pattern pat on edge 'at' (1-based) and no pulses elsewhere.
  task automatic watch(input int n, input int at, input logic [5:0] pat, input string tag);
    for (int e = 1; e <= n; e++) begin
      step();
      chk(tag, {2'b00, pulses}, {2'b00, (e == at) ? pat : 6'h00});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.i_keys = 6'h00;

    // Reset with every key pressed
    #1;
    chk("rst_pulses_t0", {2'b00, pulses}, 8'h00);
    chk("rst_level_t0", {2'b00, bus.o_keys_level}, 8'h00);
    for (int k = 0; k < 3; k++) step();
    chk("rst_pulses", {2'b00, pulses}, 8'h00);
    chk("rst_level", {2'b00, bus.o_keys_level}, 8'h00);
    chk("rst_state", {6'b0, bus.o_dbg_state}, 8'h00);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("rst_rel_pulse", {2'b00, pulses}, (e == 7) ? 8'h3F : 8'h00);
      chk("rst_rel_level", {2'b00, bus.o_keys_level}, (e >= 6) ? 8'h3F : 8'h00);
    end
    bus.i_keys = 6'h3F;
    watch(14, 0, 6'h00, "rst_release_all");
    chk("rel_all_level", {2'b00, bus.o_keys_level}, 8'h00);
    chk("rel_all_state", {6'b0, bus.o_dbg_state}, 8'h00);

    // Bounce on start_stop, then steady press
    bus.i_keys = 6'h3E; step();
    bus.i_keys = 6'h3F; step();
    bus.i_keys = 6'h3E; step();
    bus.i_keys = 6'h3F; step();
    bus.i_keys = 6'h3E;
    watch(10, 7, 6'h01, "bounce_press");
    chk("bounce_level", {2'b00, bus.o_keys_level}, 8'h01);
    bus.i_keys = 6'h3F;
    watch(10, 0, 6'h00, "bounce_release");
    chk("bounce_rel_level", {2'b00, bus.o_keys_level}, 8'h00);

    // Three-cycle glitch must be filtered out
    bus.i_keys = 6'h3E;
    for (int k = 0; k < 3; k++) step();
    bus.i_keys = 6'h3F;
    watch(12, 0, 6'h00, "glitch");
    chk("glitch_level", {2'b00, bus.o_keys_level}, 8'h00);

    // Save press and clean release
    bus.i_keys = 6'h1F;
    watch(10, 7, 6'h20, "save_press");
    chk("save_level", {2'b00, bus.o_keys_level}, 8'h20);
    bus.i_keys = 6'h3F;
    watch(5, 0, 6'h00, "save_release");
    chk("save_level_hold", {2'b00, bus.o_keys_level}, 8'h20);
    step();
    chk("save_level_fall", {2'b00, bus.o_keys_level}, 8'h00);
    watch(6, 0, 6'h00, "save_after");

    // Auto-repeat: pulses at relative 0,10,13,...,28 (press pulse on edge 7)
    rep_q = '{7, 17, 20, 23, 26, 29, 32, 35};
    bus.i_keys = 6'h2F;
    for (int e = 1; e <= 50; e++) begin
      step();
      exp_p = 6'h00;
      if (rep_q.size() > 0 && rep_q[0] == e) begin
        exp_p = 6'h10;
        void'(rep_q.pop_front());
      end
      chk("repeat", {2'b00, pulses}, {2'b00, exp_p});
      if (e == 30) bus.i_keys = 6'h3F;
    end
    chk("repeat_end_state", {6'b0, bus.o_dbg_state}, 8'h00);
    chk("repeat_end_level", {2'b00, bus.o_keys_level}, 8'h00);

    // Release lands exactly on delay expiry: d[4] falls on edge 16 as t reaches 0
    bus.i_keys = 6'h2F;
    for (int e = 1; e <= 25; e++) begin
      step();
      chk("expiry", {2'b00, pulses}, (e == 7) ? 8'h10 : 8'h00);
      if (e == 10) bus.i_keys = 6'h3F;
      if (e == 16) chk("expiry_state_delay", {6'b0, bus.o_dbg_state}, 8'h01);
      if (e == 17) chk("expiry_state_idle", {6'b0, bus.o_dbg_state}, 8'h00);
    end

    // Simultaneous seconds + hours press
    bus.i_keys = 6'h35;
    watch(10, 7, 6'h0A, "simul_press");
    chk("simul_level", {2'b00, bus.o_keys_level}, 8'h0A);
    bus.i_keys = 6'h3F;
    watch(10, 0, 6'h00, "simul_release");

    // Reset in the middle of a debounce count
    bus.i_keys = 6'h3B;
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    #1;
    chk("midrst_pulses", {2'b00, pulses}, 8'h00);
    chk("midrst_level", {2'b00, bus.o_keys_level}, 8'h00);
    chk("midrst_state", {6'b0, bus.o_dbg_state}, 8'h00);
    step();
    bus.i_keys = 6'h3F;
    step();
    step();
    rst = 1'b0;
    watch(12, 0, 6'h00, "midrst_after");
    chk("midrst_after_level", {2'b00, bus.o_keys_level}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
